// File: rtl/proj_fm_ring_pkg.sv
// Shared sizes, buffer-state encoding and small helpers for the fragment-memory ring.
// With FM_PARITY_EN defined, each stored cell gains an even-parity bit above the base.
package proj_fm_ring_pkg;

  localparam int BUFFER_COUNT      = 4;
  localparam int DEPTH             = 8;
  localparam int DATA_BITS         = 2;
  localparam int FRAG_BASES        = 2;
  localparam int READ_PORTS        = 2;
  localparam int FRAG_LEN          = FRAG_BASES * DATA_BITS;
  localparam int INDICE_LEN        = $clog2(DEPTH);
  localparam int SIGNED_INDICE_LEN = INDICE_LEN + 1;
  localparam int BUF_BITS          = $clog2(BUFFER_COUNT);
  localparam int CNT_BITS          = $clog2(BUFFER_COUNT + 1);
  localparam int NRD               = READ_PORTS * FRAG_BASES;
`ifdef FM_PARITY_EN
  localparam int CELL_BITS         = DATA_BITS + 1;
`else
  localparam int CELL_BITS         = DATA_BITS;
`endif

  typedef enum logic [2:0] {
    FM_FREE,
    FM_FILLING,
    FM_FULL,
    FM_ACTIVE,
    FM_PREV
  } fm_buf_state_t;

  function automatic logic [BUF_BITS-1:0] fm_ring_add(input logic [BUF_BITS-1:0] ptr,
                                                      input int off);
    int sum;
    sum = (int'(ptr) + off) % BUFFER_COUNT;
    return sum[BUF_BITS-1:0];
  endfunction

  function automatic logic [CELL_BITS-1:0] fm_cell_enc(input logic [DATA_BITS-1:0] d);
`ifdef FM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

endpackage

// File: rtl/proj_fm_ring_if.sv
// Write, rotate and read channels of the fragment-memory ring; out_rperr exists only
// with FM_PARITY_EN.
interface proj_fm_ring_if;
  import proj_fm_ring_pkg::*;

  logic                                  in_wvalid;
  logic [DATA_BITS-1:0]                  in_wdata;
  logic                                  out_wready;
  logic                                  chg_idx;
  logic                                  out_chg_err;
  logic [READ_PORTS-1:0]                 in_rvalid;
  logic [READ_PORTS*SIGNED_INDICE_LEN-1:0] frag_idx;
  logic [READ_PORTS-1:0]                 out_rvalid;
  logic [READ_PORTS*FRAG_LEN-1:0]        out_rdata;
  logic [READ_PORTS-1:0]                 out_rerr;
  logic [CNT_BITS-1:0]                   out_full_cnt;
`ifdef FM_PARITY_EN
  logic [READ_PORTS-1:0]                 out_rperr;
`endif

  modport master (
    output in_wvalid, in_wdata, chg_idx, in_rvalid, frag_idx,
`ifdef FM_PARITY_EN
    input  out_rperr,
`endif
    input  out_wready, out_chg_err, out_rvalid, out_rdata, out_rerr, out_full_cnt
  );

  modport slave (
    input  in_wvalid, in_wdata, chg_idx, in_rvalid, frag_idx,
`ifdef FM_PARITY_EN
    output out_rperr,
`endif
    output out_wready, out_chg_err, out_rvalid, out_rdata, out_rerr, out_full_cnt
  );

endinterface

// File: rtl/proj_fm_bank.sv
// One ring buffer: single synchronous write port, NRD combinational read taps.
// Contents are not reset; validity is tracked by the ring state in the top.
module proj_fm_bank
  import proj_fm_ring_pkg::*;
(
  input  logic                       in_clk,
  input  logic                       i_we,
  input  logic [INDICE_LEN-1:0]      i_waddr,
  input  logic [CELL_BITS-1:0]       i_wdata,
  input  logic [NRD*INDICE_LEN-1:0]  i_raddr,
  output logic [NRD*CELL_BITS-1:0]   o_rdata
);

  logic [DEPTH-1:0][CELL_BITS-1:0] r_mem;

  always_ff @(posedge in_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  for (genvar r = 0; r < NRD; r++) begin : g_rd
    assign o_rdata[r*CELL_BITS +: CELL_BITS] = r_mem[i_raddr[r*INDICE_LEN +: INDICE_LEN]];
  end

endmodule

// File: rtl/proj_fm_ring.sv
// Ring of fragment buffers: writer fills in ring order, chg_idx rotates FULL->ACTIVE->PREV->FREE.
// Reads respond one cycle later; writes stall while the write buffer is not FREE/FILLING (FM_PARITY_EN adds out_rperr).
module proj_fm_ring
  import proj_fm_ring_pkg::*;
(
  input  logic          in_clk,
  input  logic          in_rst,
  proj_fm_ring_if.slave fm
);

  fm_buf_state_t r_state     [BUFFER_COUNT];
  fm_buf_state_t w_state_nxt [BUFFER_COUNT];

  logic [BUF_BITS-1:0]   r_wr_buf, w_wr_buf_nxt;
  logic [INDICE_LEN-1:0] r_wr_cnt, w_wr_cnt_nxt;
  logic [BUF_BITS-1:0]   r_act_ptr, w_act_ptr_nxt;  // next buffer to become ACTIVE
  logic                  r_run;
  logic                  r_chg_err;

  logic [BUF_BITS-1:0]   w_act_buf, w_prev_buf;
  logic                  w_act_vld, w_prev_vld;
  logic                  w_wr_ok, w_wr_fire, w_chg_ok;
  logic [CNT_BITS-1:0]   w_full_cnt;
  logic [CELL_BITS-1:0]  w_wcell;

  assign w_act_buf  = fm_ring_add(r_act_ptr, BUFFER_COUNT - 1);
  assign w_prev_buf = fm_ring_add(r_act_ptr, BUFFER_COUNT - 2);
  assign w_act_vld  = (r_state[w_act_buf]  == FM_ACTIVE);
  assign w_prev_vld = (r_state[w_prev_buf] == FM_PREV);
  assign w_wr_ok    = r_run && (r_state[r_wr_buf] == FM_FREE || r_state[r_wr_buf] == FM_FILLING);
  assign w_wr_fire  = fm.in_wvalid && w_wr_ok;
  // Registered state only: a buffer completed this very cycle is not yet FULL here.
  assign w_chg_ok   = fm.chg_idx && (r_state[r_act_ptr] == FM_FULL);
  assign w_wcell    = fm_cell_enc(fm.in_wdata);

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      for (int b = 0; b < BUFFER_COUNT; b++) r_state[b] <= FM_FREE;
      r_wr_buf  <= '0;
      r_wr_cnt  <= '0;
      r_act_ptr <= '0;
      r_run     <= 1'b0;
      r_chg_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_buf  <= w_wr_buf_nxt;
      r_wr_cnt  <= w_wr_cnt_nxt;
      r_act_ptr <= w_act_ptr_nxt;
      r_run     <= 1'b1;
      r_chg_err <= fm.chg_idx && !w_chg_ok;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_wr_buf_nxt  = r_wr_buf;
    w_wr_cnt_nxt  = r_wr_cnt;
    w_act_ptr_nxt = r_act_ptr;
    if (w_chg_ok) begin
      w_state_nxt[r_act_ptr] = FM_ACTIVE;
      if (w_act_vld)  w_state_nxt[w_act_buf]  = FM_PREV;
      if (w_prev_vld) w_state_nxt[w_prev_buf] = FM_FREE;
      w_act_ptr_nxt = fm_ring_add(r_act_ptr, 1);
    end
    if (w_wr_fire) begin
      if (r_wr_cnt == INDICE_LEN'(DEPTH - 1)) begin
        w_state_nxt[r_wr_buf] = FM_FULL;
        w_wr_cnt_nxt          = '0;
        w_wr_buf_nxt          = fm_ring_add(r_wr_buf, 1);
      end else begin
        w_state_nxt[r_wr_buf] = FM_FILLING;
        w_wr_cnt_nxt          = r_wr_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_full_cnt = '0;
    for (int b = 0; b < BUFFER_COUNT; b++) begin
      if (r_state[b] == FM_FULL) w_full_cnt = w_full_cnt + 1'b1;
    end
  end

  logic [BUFFER_COUNT-1:0][NRD*CELL_BITS-1:0] w_bank_rd;
  logic [NRD*INDICE_LEN-1:0]                  w_raddr;

  for (genvar b = 0; b < BUFFER_COUNT; b++) begin : g_bank
    proj_fm_bank u_bank (
      .in_clk  (in_clk),
      .i_we    (w_wr_fire && (r_wr_buf == BUF_BITS'(b))),
      .i_waddr (r_wr_cnt),
      .i_wdata (w_wcell),
      .i_raddr (w_raddr),
      .o_rdata (w_bank_rd[b])
    );
  end

  logic [READ_PORTS-1:0]          w_rd_ok;
  logic [READ_PORTS*FRAG_LEN-1:0] w_frag;
`ifdef FM_PARITY_EN
  logic [READ_PORTS-1:0]          w_rd_perr;
`endif

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    logic signed [SIGNED_INDICE_LEN-1:0] w_idx;
`ifdef FM_PARITY_EN
    logic [FRAG_BASES-1:0] w_perr_b;
    assign w_rd_perr[p] = |w_perr_b;
`endif
    assign w_idx = fm.frag_idx[p*SIGNED_INDICE_LEN +: SIGNED_INDICE_LEN];
    // The index width already bounds idx below at -DEPTH.
    assign w_rd_ok[p] = w_act_vld && (int'(w_idx) <= DEPTH - FRAG_BASES) &&
                        (!w_idx[SIGNED_INDICE_LEN-1] || w_prev_vld);

    for (genvar k = 0; k < FRAG_BASES; k++) begin : g_base
      localparam int N = p*FRAG_BASES + k;
      logic [SIGNED_INDICE_LEN-1:0] w_pos;
      logic [BUF_BITS-1:0]          w_sel;
      logic [CELL_BITS-1:0]         w_cell;
      // Negative positions wrap to DEPTH+pos in the low bits and select PREV via the sign.
      assign w_pos  = w_idx + SIGNED_INDICE_LEN'(k);
      assign w_sel  = w_pos[SIGNED_INDICE_LEN-1] ? w_prev_buf : w_act_buf;
      assign w_raddr[N*INDICE_LEN +: INDICE_LEN] = w_pos[INDICE_LEN-1:0];
      assign w_cell = w_bank_rd[w_sel][N*CELL_BITS +: CELL_BITS];
      assign w_frag[p*FRAG_LEN + k*DATA_BITS +: DATA_BITS] = w_cell[DATA_BITS-1:0];
`ifdef FM_PARITY_EN
      assign w_perr_b[k] = ^w_cell;
`endif
    end
  end

  logic [READ_PORTS-1:0]          r_rvalid, r_rerr;
  logic [READ_PORTS*FRAG_LEN-1:0] r_rdata;
`ifdef FM_PARITY_EN
  logic [READ_PORTS-1:0]          r_rperr;
`endif

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_rvalid <= '0;
      r_rerr   <= '0;
      r_rdata  <= '0;
`ifdef FM_PARITY_EN
      r_rperr  <= '0;
`endif
    end else begin
      r_rvalid <= fm.in_rvalid;
      r_rerr   <= fm.in_rvalid & ~w_rd_ok;
`ifdef FM_PARITY_EN
      r_rperr  <= fm.in_rvalid & w_rd_ok & w_rd_perr;
`endif
      for (int p = 0; p < READ_PORTS; p++) begin
        r_rdata[p*FRAG_LEN +: FRAG_LEN] <= (fm.in_rvalid[p] && w_rd_ok[p]) ?
                                           w_frag[p*FRAG_LEN +: FRAG_LEN] : '0;
      end
    end
  end

  assign fm.out_wready   = w_wr_ok;
  assign fm.out_chg_err  = r_chg_err;
  assign fm.out_rvalid   = r_rvalid;
  assign fm.out_rdata    = r_rdata;
  assign fm.out_rerr     = r_rerr;
  assign fm.out_full_cnt = w_full_cnt;
`ifdef FM_PARITY_EN
  assign fm.out_rperr    = r_rperr;
`endif

endmodule

// File: tb/tb_proj_fm_ring.sv
// Directed bench for proj_fm_ring: read expectations queue per port, a negedge monitor pops them.
// With FM_PARITY_EN defined, a corrupted bank cell must raise out_rperr.
module tb_proj_fm_ring;
  import proj_fm_ring_pkg::*;

  typedef struct {
    logic                err;
    logic [FRAG_LEN-1:0] data;
    int                  cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q0[$];
  exp_t q1[$];

  proj_fm_ring_if bus();

  proj_fm_ring dut (
    .in_clk (clk),
    .in_rst (rst),
    .fm     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_cmp(input int p, input logic err, input logic [FRAG_LEN-1:0] data);
    exp_t e;
    logic empty;
    empty = (p == 0) ? (q0.size() == 0) : (q1.size() == 0);
    checks++;
    if (empty) begin
      errors++;
      $display("FAIL rd_port%0d_unexpected: got rvalid=1 err=%0b data=%b at cyc %0d, required no response",
               p, err, data, cyc);
    end else begin
      if (p == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      if (err !== e.err || data !== e.data || cyc != e.cyc) begin
        errors++;
        $display("FAIL rd_port%0d: got err=%0b data=%b cyc=%0d, required err=%0b data=%b cyc=%0d",
                 p, err, data, cyc, e.err, e.data, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_rvalid[0] === 1'b1) pop_cmp(0, bus.out_rerr[0], bus.out_rdata[FRAG_LEN-1:0]);
      if (bus.out_rvalid[1] === 1'b1) pop_cmp(1, bus.out_rerr[1], bus.out_rdata[2*FRAG_LEN-1:FRAG_LEN]);
    end
  end

  task automatic write_base(input logic [DATA_BITS-1:0] d, input logic with_chg);
    int n;
    n = 0;
    bus.in_wvalid = 1'b1;
    bus.in_wdata  = d;
    while (bus.out_wready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (bus.out_wready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wr_timeout: got out_wready=%0b after %0d cycles, required 1", bus.out_wready, n);
    end
    bus.chg_idx = with_chg;
    tick();
    bus.in_wvalid = 1'b0;
    bus.chg_idx   = 1'b0;
  endtask

  task automatic pulse_chg();
    bus.chg_idx = 1'b1;
    tick();
    bus.chg_idx = 1'b0;
  endtask

  task automatic rd(input logic v0, input int i0, input logic e0, input logic [FRAG_LEN-1:0] d0,
                    input logic v1, input int i1, input logic e1, input logic [FRAG_LEN-1:0] d1);
    exp_t e;
    bus.in_rvalid = {v1, v0};
    bus.frag_idx  = {SIGNED_INDICE_LEN'(i1), SIGNED_INDICE_LEN'(i0)};
    if (v0) begin
      e.err = e0; e.data = d0; e.cyc = cyc + 1;
      q0.push_back(e);
    end
    if (v1) begin
      e.err = e1; e.data = d1; e.cyc = cyc + 1;
      q1.push_back(e);
    end
    tick();
    bus.in_rvalid = '0;
  endtask

  initial begin
    bus.in_wvalid = 1'b0;
    bus.in_wdata  = '0;
    bus.chg_idx   = 1'b0;
    bus.in_rvalid = '0;
    bus.frag_idx  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wready",    32'(bus.out_wready),   0);
    check("rst_full_cnt",  32'(bus.out_full_cnt), 0);
    check("rst_rvalid",    32'(bus.out_rvalid),   0);
    check("rst_chg_err",   32'(bus.out_chg_err),  0);
    rst = 1'b0;
    tick();
    check("wready_after_rst", 32'(bus.out_wready), 1);

    // buf0 = 0,1,2,3,0,1,2,3
    for (int i = 0; i < 8; i++) write_base(DATA_BITS'(i), 1'b0);
    check("full_cnt_buf0", 32'(bus.out_full_cnt), 1);
    pulse_chg();
    check("chg1_err", 32'(bus.out_chg_err), 0);
    check("chg1_full_cnt", 32'(bus.out_full_cnt), 0);
    rd(1, 0, 0, 4'b0100, 0, 0, 0, 4'b0000);
    rd(1, 6, 0, 4'b1110, 0, 0, 0, 4'b0000);
    rd(1, -1, 1, 4'b0000, 1, 7, 1, 4'b0000);

    pulse_chg();
    check("chg_none_err", 32'(bus.out_chg_err), 1);
    tick();
    check("chg_none_err_clear", 32'(bus.out_chg_err), 0);
    rd(1, 0, 0, 4'b0100, 1, 6, 0, 4'b1110);

    // buf1 = all 3s; rotate -> PREV=buf0, ACTIVE=buf1
    for (int i = 0; i < 8; i++) write_base(2'd3, 1'b0);
    pulse_chg();
    rd(1, -1, 0, 4'b1111, 1, 7, 1, 4'b0000);
    rd(1, -8, 0, 4'b0100, 1, 0, 0, 4'b1111);
    rd(1, -2, 0, 4'b1110, 1, 6, 0, 4'b1111);

    // buf2 = all 1s; read in the same cycle as the rotation sees the old mapping
    for (int i = 0; i < 8; i++) write_base(2'd1, 1'b0);
    bus.chg_idx = 1'b1;
    rd(1, -1, 0, 4'b1111, 1, 0, 0, 4'b1111);
    bus.chg_idx = 1'b0;
    check("rot_read_chg_err", 32'(bus.out_chg_err), 0);
    rd(1, -1, 0, 4'b0111, 1, 0, 0, 4'b0101);

    // buf3 = all 2s; chg_idx together with the final write must be rejected
    for (int i = 0; i < 7; i++) write_base(2'd2, 1'b0);
    write_base(2'd2, 1'b1);
    check("late_full_chg_err", 32'(bus.out_chg_err), 1);
    check("late_full_cnt", 32'(bus.out_full_cnt), 1);
    pulse_chg();
    check("late_chg_ok_err", 32'(bus.out_chg_err), 0);
    check("late_chg_full_cnt", 32'(bus.out_full_cnt), 0);
    rd(1, 0, 0, 4'b1010, 1, -1, 0, 4'b1001);

    // reset while buf0 FULL, buf1 part filled and a response just registered
    for (int i = 0; i < 11; i++) write_base(DATA_BITS'(i), 1'b0);
    check("pre_rst_full_cnt", 32'(bus.out_full_cnt), 1);
    bus.in_rvalid = 2'b11;
    bus.frag_idx  = '0;
    tick();
    rst = 1'b1;
    bus.in_rvalid = '0;
    #1;
    check("rst_mid_rvalid",   32'(bus.out_rvalid),   0);
    check("rst_mid_full_cnt", 32'(bus.out_full_cnt), 0);
    check("rst_mid_wready",   32'(bus.out_wready),   0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("wready_after_rst2", 32'(bus.out_wready), 1);

    // fill all four buffers, then release the stall with three rotations
    for (int i = 0; i < 32; i++) write_base(DATA_BITS'(i), 1'b0);
    check("stall_wready", 32'(bus.out_wready), 0);
    check("stall_full_cnt", 32'(bus.out_full_cnt), 4);
    pulse_chg();
    check("stall_chg1_wready", 32'(bus.out_wready), 0);
    pulse_chg();
    check("stall_chg2_wready", 32'(bus.out_wready), 0);
    check("stall_chg2_full_cnt", 32'(bus.out_full_cnt), 2);
    pulse_chg();
    check("stall_chg3_wready", 32'(bus.out_wready), 1);
    check("stall_chg3_full_cnt", 32'(bus.out_full_cnt), 1);
    rd(1, -1, 0, 4'b0011, 1, -8, 0, 4'b0100);
    write_base(2'd1, 1'b0);
    check("freed_buf_full_cnt", 32'(bus.out_full_cnt), 1);

`ifdef FM_PARITY_EN
    force dut.g_bank[2].u_bank.r_mem = 24'h000001;
    rd(1, 0, 0, 4'b0001, 0, 0, 0, 4'b0000);
    check("parity_err_flag", 32'(bus.out_rperr[0]), 1);
    release dut.g_bank[2].u_bank.r_mem;
`endif

    repeat (3) tick();
    check("scoreboard_drained", 32'(q0.size() + q1.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
